// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: one request at a time,
// fixed access latency, RV32I byte/half/word lane handling and load extension.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW2   = ADDR_W + 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [AW2-1:0]   r_addr;
  logic [31:0]      r_wdata;
  logic [2:0]       r_f3;
  logic [31:0]      r_mem [0:DEPTH-1];
  logic             r_resp_valid;
  logic [31:0]      r_resp_rdata;
  logic             r_resp_err;

  logic             w_accept;
  logic             w_req_err;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_enter_resp;
  logic             w_op_we;
  logic [AW2-1:0]   w_op_addr;
  logic [31:0]      w_op_wdata;
  logic [2:0]       w_op_f3;
  logic             w_op_err;
  logic [ADDR_W-1:0] w_word_idx;
  logic [31:0]      w_rd_word;
  logic [7:0]       w_rd_byte;
  logic [15:0]      w_rd_half;
  logic [31:0]      w_load_data;
  logic [3:0]       w_be;
  logic [31:0]      w_wlane;

  assign req_ready  = (r_state != S_WAIT);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign w_accept   = req_valid & req_ready;

  // Request legality, evaluated on the live request inputs at acceptance
  always_comb begin
    w_req_err = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: w_req_err = 1'b1;
      default: ;
    endcase
    if (req_we && req_funct3[2]) w_req_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) w_req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) w_req_err = 1'b1;
    if ((req_addr >> AW2) != 32'd0) w_req_err = 1'b1;
  end

  // Operation feeding the RESP-entry edge: live inputs when entering from accept, else latched
  assign w_op_we    = w_accept ? req_we : r_we;
  assign w_op_addr  = w_accept ? req_addr[AW2-1:0] : r_addr;
  assign w_op_wdata = w_accept ? req_wdata : r_wdata;
  assign w_op_f3    = w_accept ? req_funct3 : r_f3;
  assign w_op_err   = w_accept & w_req_err;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == '0) w_next_state = S_RESP;
        else             w_next_cnt   = r_cnt - CNT_W'(1);
      end
      default: begin
        if (w_accept) begin
          if (w_req_err || LATENCY == 1) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_WAIT;
            w_next_cnt   = CNT_INIT;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
    endcase
  end

  assign w_enter_resp = (w_next_state == S_RESP);

  assign w_word_idx = w_op_addr[AW2-1:2];
  assign w_rd_word  = r_mem[w_word_idx];
  assign w_rd_byte  = w_rd_word[{w_op_addr[1:0], 3'b000} +: 8];
  assign w_rd_half  = w_op_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_load_data = 32'd0;
    w_be        = 4'b1111;
    w_wlane     = w_op_wdata;
    case (w_op_f3)
      3'b000:  w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
      3'b001:  w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
      3'b010:  w_load_data = w_rd_word;
      3'b100:  w_load_data = {24'd0, w_rd_byte};
      3'b101:  w_load_data = {16'd0, w_rd_half};
      default: w_load_data = 32'd0;
    endcase
    case (w_op_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_op_addr[1:0];
        w_wlane = {4{w_op_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_op_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_op_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr[AW2-1:0];
      r_wdata <= req_wdata;
      r_f3    <= req_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_enter_resp;
      r_resp_err   <= w_enter_resp & w_op_err;
      r_resp_rdata <= (w_enter_resp && !w_op_err && !w_op_we) ? w_load_data : 32'd0;
    end
  end

  // Store commit on the RESP-entry edge; a reset on that edge suppresses it
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && !w_op_err && w_op_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 2, 1, 4) checked
// against a byte-level memory model, a directed vector table and corner sequences.
module tb_dmem_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned NI = 3;

  logic        clk = 1'b0;
  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic [2:0]  req_funct3 [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    dmem_responder #(.ADDR_W(AW), .LATENCY(L)) u_dut (
      .clk(clk), .rst(rst[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_we(req_we[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .req_funct3(req_funct3[g]), .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
    );
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [NI][1 << AW];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [23];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  // Reference: size from funct3, legality from the RV32I rules, byte-wise memory access
  function automatic void model(input int k, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic err, output logic [31:0] rd);
    int nb;
    int b;
    int w;
    logic [31:0] t;
    err = 1'b0;
    rd  = 32'd0;
    nb  = 1;
    case (f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    err = 1'b1;
    endcase
    if (we && f3 >= 3'd3) err = 1'b1;
    if ((a % nb) != 0) err = 1'b1;
    if (a >= (32'd1 << (AW + 2))) err = 1'b1;
    if (err) return;
    w = int'(a[AW+1:2]);
    b = int'(a[1:0]);
    t = mdl[k][w];
    if (we) begin
      for (int i = 0; i < nb; i++) t[8*(b+i) +: 8] = wd[8*i +: 8];
      mdl[k][w] = t;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i < nb) rd[8*i +: 8] = t[8*(b+i) +: 8];
        else if (f3 < 3'd4 && rd[8*nb-1]) rd[8*i +: 8] = 8'hFF;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    req_valid[k]  = 1'b0;
    req_we[k]     = 1'($urandom);
    req_addr[k]   = $urandom;
    req_wdata[k]  = $urandom;
    req_funct3[k] = 3'($urandom);
  endtask

  task automatic drive(input int k, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    req_valid[k]  = 1'b1;
    req_we[k]     = we;
    req_addr[k]   = a;
    req_wdata[k]  = wd;
    req_funct3[k] = f3;
  endtask

  // One isolated request; called and returning just after a falling edge
  task automatic txn(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input logic exp_err, input logic [31:0] exp_rd,
                     input string nm);
    int lat;
    int n;
    lat = exp_err ? 1 : lat_of(k);
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({nm, " ready-timeout"}, 32'd0, 32'd1);
    drive(k, we, a, wd, f3);
    @(posedge clk);
    @(negedge clk);
    idle_inputs(k);
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      chk({nm, " valid"}, 32'(resp_valid[k]), 32'(c == lat));
      chk({nm, " ready"}, 32'(req_ready[k]), 32'(c == lat));
    end
    chk({nm, " rdata"}, resp_rdata[k], exp_rd);
    chk({nm, " err"}, 32'(resp_err[k]), 32'(exp_err));
    @(negedge clk);
    chk({nm, " idle-valid"}, 32'(resp_valid[k]), 32'd0);
    chk({nm, " idle-rdata"}, resp_rdata[k], 32'd0);
    chk({nm, " idle-err"}, 32'(resp_err[k]), 32'd0);
  endtask

  task automatic mtxn(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input string nm);
    logic        e;
    logic [31:0] r;
    model(k, we, a, wd, f3, e, r);
    txn(k, we, a, wd, f3, e, r, nm);
  endtask

  // Store accepted, then reset raised d cycles later: no response, no commit
  task automatic abort_store(input int k, input logic [31:0] a, input logic [31:0] wd,
                             input int d, input string nm);
    drive(k, 1'b1, a, wd, 3'b010);
    @(posedge clk);
    @(negedge clk);
    idle_inputs(k);
    for (int c = 1; c < d; c++) begin
      chk({nm, " pre-valid"}, 32'(resp_valid[k]), 32'd0);
      @(negedge clk);
    end
    rst[k] = 1'b1;
    chk({nm, " pre-valid"}, 32'(resp_valid[k]), 32'd0);
    @(negedge clk);
    rst[k] = 1'b0;
    chk({nm, " rst-ready"}, 32'(req_ready[k]), 32'd1);
    chk({nm, " rst-rdata"}, resp_rdata[k], 32'd0);
    chk({nm, " rst-err"}, 32'(resp_err[k]), 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk({nm, " post-valid"}, 32'(resp_valid[k]), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] exp_rd [3];

    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      idle_inputs(k);
    end

    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 3'b010, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        3'b010, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h11,       32'h00000080, 3'b000, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h11,       32'h0,        3'b000, 1'b0, 32'hFFFFFF80};
    tbl[4]  = '{1'b0, 32'h11,       32'h0,        3'b100, 1'b0, 32'h00000080};
    tbl[5]  = '{1'b0, 32'h10,       32'h0,        3'b010, 1'b0, 32'hDEAD80EF};
    tbl[6]  = '{1'b1, 32'h13,       32'h0000FFFF, 3'b001, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h10,       32'h0,        3'b010, 1'b0, 32'hDEAD80EF};
    tbl[8]  = '{1'b0, 32'h10,       32'h0,        3'b011, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 32'h1000,     32'h0,        3'b010, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'h12,       32'h0,        3'b001, 1'b0, 32'hFFFFDEAD};
    tbl[11] = '{1'b0, 32'h12,       32'h0,        3'b101, 1'b0, 32'h0000DEAD};
    tbl[12] = '{1'b0, 32'h11,       32'h0,        3'b010, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 32'h10,       32'h12345678, 3'b100, 1'b1, 32'h0};
    tbl[14] = '{1'b0, 32'h13,       32'h0,        3'b000, 1'b0, 32'hFFFFFFDE};
    tbl[15] = '{1'b1, 32'h12,       32'hABCD1234, 3'b001, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 32'h10,       32'h0,        3'b010, 1'b0, 32'h123480EF};
    tbl[17] = '{1'b1, 32'hFFC,      32'hCAFEF00D, 3'b010, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 32'hFFC,      32'h0,        3'b010, 1'b0, 32'hCAFEF00D};
    tbl[19] = '{1'b0, 32'h10,       32'h0,        3'b001, 1'b0, 32'hFFFF80EF};
    tbl[20] = '{1'b0, 32'h10,       32'h0,        3'b100, 1'b0, 32'h000000EF};
    tbl[21] = '{1'b1, 32'hFFFFFFFC, 32'h55555555, 3'b010, 1'b1, 32'h0};
    tbl[22] = '{1'b0, 32'hFFC,      32'h0,        3'b010, 1'b0, 32'hCAFEF00D};

    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset%0d valid", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("reset%0d rdata", k), resp_rdata[k], 32'd0);
      chk($sformatf("reset%0d err", k), 32'(resp_err[k]), 32'd0);
      chk($sformatf("reset%0d ready", k), 32'(req_ready[k]), 32'd1);
      rst[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk($sformatf("post-reset%0d ready", k), 32'(req_ready[k]), 32'd1);

    for (int i = 0; i < 23; i++) begin
      model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, e, r);
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, tbl[i].err, tbl[i].rdata,
          $sformatf("vec%0d", i));
    end

    // Back-to-back on LATENCY=2: load accepted in the store's RESP cycle
    model(0, 1'b1, 32'h20, 32'h12345678, 3'b010, e, r);
    model(0, 1'b0, 32'h20, 32'h0, 3'b010, e, r);
    drive(0, 1'b1, 32'h20, 32'h12345678, 3'b010);
    @(posedge clk);
    @(negedge clk);
    chk("b2b c1 valid", 32'(resp_valid[0]), 32'd0);
    chk("b2b c1 ready", 32'(req_ready[0]), 32'd0);
    drive(0, 1'b0, 32'h20, 32'h0, 3'b010);
    @(negedge clk);
    chk("b2b c2 valid", 32'(resp_valid[0]), 32'd1);
    chk("b2b c2 ready", 32'(req_ready[0]), 32'd1);
    chk("b2b c2 rdata", resp_rdata[0], 32'd0);
    @(negedge clk);
    idle_inputs(0);
    chk("b2b c3 valid", 32'(resp_valid[0]), 32'd0);
    chk("b2b c3 ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    chk("b2b c4 valid", 32'(resp_valid[0]), 32'd1);
    chk("b2b c4 rdata", resp_rdata[0], r);
    chk("b2b c4 err", 32'(resp_err[0]), 32'd0);
    @(negedge clk);
    chk("b2b c5 valid", 32'(resp_valid[0]), 32'd0);

    // LATENCY=1: three consecutive loads give three consecutive responses
    mtxn(1, 1'b1, 32'h40, 32'h11111111, 3'b010, "l1 init0");
    mtxn(1, 1'b1, 32'h44, 32'h22222222, 3'b010, "l1 init1");
    mtxn(1, 1'b1, 32'h48, 32'h80808080, 3'b010, "l1 init2");
    model(1, 1'b0, 32'h40, 32'h0, 3'b010, e, exp_rd[0]);
    model(1, 1'b0, 32'h44, 32'h0, 3'b001, e, exp_rd[1]);
    model(1, 1'b0, 32'h49, 32'h0, 3'b000, e, exp_rd[2]);
    drive(1, 1'b0, 32'h40, 32'h0, 3'b010);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("l1 seq%0d valid", i), 32'(resp_valid[1]), 32'd1);
      chk($sformatf("l1 seq%0d ready", i), 32'(req_ready[1]), 32'd1);
      chk($sformatf("l1 seq%0d rdata", i), resp_rdata[1], exp_rd[i]);
      if (i == 0) drive(1, 1'b0, 32'h44, 32'h0, 3'b001);
      else if (i == 1) drive(1, 1'b0, 32'h49, 32'h0, 3'b000);
      else idle_inputs(1);
    end
    @(negedge clk);
    chk("l1 seq end valid", 32'(resp_valid[1]), 32'd0);

    // Reset mid-operation: aborted stores never land
    mtxn(2, 1'b1, 32'h30, 32'h00000000, 3'b010, "abort4 preload");
    abort_store(2, 32'h30, 32'hAAAA5555, 1, "abort4");
    mtxn(2, 1'b0, 32'h30, 32'h0, 3'b010, "abort4 readback");
    abort_store(2, 32'h30, 32'hAAAA5555, 3, "abort4 late");
    mtxn(2, 1'b0, 32'h30, 32'h0, 3'b010, "abort4 late readback");
    abort_store(0, 32'h10, 32'h55555555, 1, "abort2");
    mtxn(0, 1'b0, 32'h10, 32'h0, 3'b010, "abort2 readback");

    // Randomized traffic against the model
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < 16; w++)
        mtxn(k, 1'b1, 32'(w * 4), $urandom, 3'b010, $sformatf("rinit%0d", k));
      for (int i = 0; i < 120; i++) begin
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(12, 31));
        mtxn(k, 1'($urandom), a, $urandom, 3'($urandom),
             $sformatf("rand%0d.%0d", k, i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
